// File: rtl/instr_packer_pkg.sv
// Shared encodings for the instruction packer: immediate formats, FSM states,
// error codes and immediate range limits.
package instr_packer_pkg;

    // Same coding the datapath immediate extender consumes.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_R = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_DONE  = 2'b10,
        ST_ERR   = 2'b11
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_RANGE    = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    localparam int I_MIN = -2048;
    localparam int I_MAX = 2047;
    localparam int B_MIN = -4096;
    localparam int B_MAX = 4094;

endpackage

// File: rtl/instr_packer_imm_pack.sv
// Combinational packer: places decoded fields and the immediate into a 32-bit
// instruction word for the selected format and flags out-of-range immediates.
module imm_pack
    import instr_packer_pkg::*;
(
    input  logic [1:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] word,
    output logic        range_ok
);

    logic i_fits;
    logic b_fits;

    // Branch offsets are in bytes but must be halfword aligned.
    assign i_fits = ($signed(imm) >= I_MIN) && ($signed(imm) <= I_MAX);
    assign b_fits = ($signed(imm) >= B_MIN) && ($signed(imm) <= B_MAX) && !imm[0];

    always_comb begin
        word     = '0;
        range_ok = 1'b0;
        case (imm_src)
            IMM_I: begin
                word     = {imm[11:0], rs1, funct3, rd, opcode};
                range_ok = i_fits;
            end
            IMM_S: begin
                word     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_ok = i_fits;
            end
            IMM_B: begin
                word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_ok = b_fits;
            end
            default: begin
                word     = {funct7, rs2, rs1, funct3, rd, opcode};
                range_ok = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_packer.sv
// Program loader: accepts field bundles, packs them and writes consecutive words
// to instruction memory, ending in a sticky DONE or ERR state.
module instr_packer
    import instr_packer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [1:0]       imm_src,
    input  logic [31:0]      imm,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] word_count,
    output state_t           dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [CNT_W-1:0] count_inc;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             last_q, last_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             in_ready_q, in_ready_d;
    logic             mem_we_q, mem_we_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      pack_word;
    logic             range_ok;

    imm_pack u_imm_pack (
        .imm_src  (imm_src),
        .imm      (imm),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .word     (pack_word),
        .range_ok (range_ok)
    );

    assign count_inc = word_count_q + CNT_W'(1);

    // Handshake: a bundle transfers on a rising edge where in_valid and in_ready
    // are both high; in_ready is high only in IDLE, and a write completes on the
    // edge where mem_we and mem_ack are both high.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        mem_wdata_d  = mem_wdata_q;
        last_d       = last_q;
        err_code_d   = err_code_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!range_ok) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_RANGE;
                    end else begin
                        mem_wdata_d = pack_word;
                        last_d      = in_last;
                        state_d     = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    word_count_d = count_inc;
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else if (count_inc == CNT_MAX) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_OVERFLOW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = state_q;
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        in_ready_d = (state_d == ST_IDLE);
        mem_we_d   = (state_d == ST_WRITE);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
        mem_addr_d = BASE_ADDR + (32'(word_count_d) << 2);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
            mem_addr_q   <= BASE_ADDR;
            mem_wdata_q  <= '0;
            last_q       <= 1'b0;
            err_code_q   <= ERR_NONE;
            in_ready_q   <= 1'b1;
            mem_we_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            last_q       <= last_d;
            err_code_q   <= err_code_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign word_count = word_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_packer.sv
// Self-checking bench for instr_packer: directed scenarios plus randomized
// bundles checked against an arithmetic reference model.
module tb_instr_packer;
    import instr_packer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [1:0]  imm_src = 2'b00;
    logic [31:0] imm = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        mem_ack = 1'b0;

    logic        in_ready, mem_we, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  err_code;
    logic [8:0]  word_count;
    state_t      dbg_state;

    logic        in_ready2, mem_we2, done2, err2;
    logic [31:0] mem_addr2, mem_wdata2;
    logic [1:0]  err_code2;
    logic [1:0]  word_count2;
    state_t      dbg_state2;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    instr_packer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .imm_src(imm_src), .imm(imm), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .done(done), .err(err), .err_code(err_code),
        .word_count(word_count), .dbg_state(dbg_state)
    );

    instr_packer #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_last(in_last), .imm_src(imm_src), .imm(imm), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_ack(mem_ack), .done(done2), .err(err2), .err_code(err_code2),
        .word_count(word_count2), .dbg_state(dbg_state2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reference model: field placement by shifts and masks on plain integers.
    function automatic logic [31:0] ref_word(input logic [1:0] f, input int im,
                                             input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2);
        logic [31:0] u;
        logic [31:0] w;
        u = im;
        w = 32'(op) | (32'(f3) << 12) | (32'(s1) << 15);
        case (f)
            2'd0: w = w | (32'(d) << 7) | ((u & 32'hFFF) << 20);
            2'd1: w = w | (32'(s2) << 20) | ((u & 32'h1F) << 7) | (((u >> 5) & 32'h7F) << 25);
            2'd2: w = w | (32'(s2) << 20) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7)
                        | (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 32'h1) << 31);
            default: w = w | (32'(d) << 7) | (32'(s2) << 20) | (32'(f7) << 25);
        endcase
        return w;
    endfunction

    function automatic bit ref_ok(input logic [1:0] f, input int im);
        if (f == 2'd0 || f == 2'd1) return (im >= -2048) && (im <= 2047);
        if (f == 2'd2) return (im >= -4096) && (im <= 4094) && ((im % 2) == 0);
        return 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        mem_ack = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Presents one bundle for a single cycle; returns on the following negedge.
    task automatic drive(input logic [1:0] f, input int im, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic l);
        imm_src = f; imm = im; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; in_last = l; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic ack_once();
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({in_ready, mem_we, done, err, err_code} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_flags: got %b required 100000", {in_ready, mem_we, done, err, err_code});
        end
        total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || word_count !== 9'd0) begin
            bad++;
            $display("FAIL reset_regs: got addr=%h data=%h cnt=%0d required 0/0/0", mem_addr, mem_wdata, word_count);
        end
        total++;
        if (dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_i_type();
        do_reset();
        drive(2'd0, 5, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 1'b0);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h00500093) begin
            bad++;
            $display("FAIL i_write: got we=%b addr=%h data=%h required 1/0/00500093", mem_we, mem_addr, mem_wdata);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL i_busy: got in_ready=%b required 0", in_ready);
        end
        ack_once();
        total++;
        if (in_ready !== 1'b1 || word_count !== 9'd1 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL i_after_ack: got rdy=%b cnt=%0d we=%b required 1/1/0", in_ready, word_count, mem_we);
        end
    endtask

    task automatic test_s_b();
        logic [31:0] exp_b;
        do_reset();
        drive(2'd1, 8, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd0, 5'd2, 1'b0);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h00202423) begin
            bad++;
            $display("FAIL s_write: got we=%b addr=%h data=%h required 1/0/00202423", mem_we, mem_addr, mem_wdata);
        end
        ack_once();
        exp_b = ref_word(2'd2, -4, 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2);
        drive(2'd2, -4, 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 1'b1);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'hFE208EE3 || mem_wdata !== exp_b) begin
            bad++;
            $display("FAIL b_write: got we=%b addr=%h data=%h required 1/4/FE208EE3", mem_we, mem_addr, mem_wdata);
        end
        ack_once();
        total++;
        if (done !== 1'b1 || in_ready !== 1'b0 || word_count !== 9'd2 || err !== 1'b0) begin
            bad++;
            $display("FAIL sb_done: got done=%b rdy=%b cnt=%0d err=%b required 1/0/2/0", done, in_ready, word_count, err);
        end
        repeat (2) @(negedge clk);
        total++;
        if (done !== 1'b1 || dbg_state !== ST_DONE) begin
            bad++;
            $display("FAIL sb_done_sticky: got done=%b state=%0d required 1/%0d", done, dbg_state, ST_DONE);
        end
    endtask

    task automatic test_r_stall();
        do_reset();
        drive(2'd3, 0, 7'b0110011, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h002081B3 || word_count !== 9'd0) begin
                bad++;
                $display("FAIL r_stall[%0d]: got we=%b addr=%h data=%h cnt=%0d required 1/0/002081B3/0",
                         i, mem_we, mem_addr, mem_wdata, word_count);
            end
            if (i == 5) mem_ack = 1'b1;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        total++;
        if (word_count !== 9'd1 || mem_we !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL r_after_ack: got cnt=%0d we=%b rdy=%b required 1/0/1", word_count, mem_we, in_ready);
        end
    endtask

    task automatic test_range_errors();
        do_reset();
        drive(2'd0, 2048, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 1'b0);
        total++;
        if (err !== 1'b1 || err_code !== 2'b01 || mem_we !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL range_i: got err=%b code=%b we=%b rdy=%b required 1/01/0/0", err, err_code, mem_we, in_ready);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        total++;
        if (mem_we !== 1'b0 || word_count !== 9'd0 || err !== 1'b1) begin
            bad++;
            $display("FAIL range_i_sticky: got we=%b cnt=%0d err=%b required 0/0/1", mem_we, word_count, err);
        end
        do_reset();
        drive(2'd2, 3, 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 1'b0);
        total++;
        if (err !== 1'b1 || err_code !== 2'b01 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL range_b_odd: got err=%b code=%b we=%b required 1/01/0", err, err_code, mem_we);
        end
        do_reset();
        drive(2'd2, 4094, 7'b1100011, 3'b001, 7'd0, 5'd0, 5'd4, 5'd5, 1'b0);
        total++;
        if (err !== 1'b0 || mem_we !== 1'b1 ||
            mem_wdata !== ref_word(2'd2, 4094, 7'b1100011, 3'b001, 7'd0, 5'd0, 5'd4, 5'd5)) begin
            bad++;
            $display("FAIL range_b_max: got err=%b we=%b data=%h required 0/1/%h", err, mem_we, mem_wdata,
                     ref_word(2'd2, 4094, 7'b1100011, 3'b001, 7'd0, 5'd0, 5'd4, 5'd5));
        end
        ack_once();
    endtask

    task automatic test_overflow();
        do_reset();
        drive(2'd0, 1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 1'b0);
        ack_once();
        drive(2'd0, 2, 7'b0010011, 3'b000, 7'd0, 5'd2, 5'd0, 5'd0, 1'b0);
        total++;
        if (mem_we2 !== 1'b1 || mem_addr2 !== 32'h4) begin
            bad++;
            $display("FAIL ovf_second: got we=%b addr=%h required 1/4", mem_we2, mem_addr2);
        end
        ack_once();
        total++;
        if (err2 !== 1'b1 || err_code2 !== 2'b10 || word_count2 !== 2'd2 || in_ready2 !== 1'b0) begin
            bad++;
            $display("FAIL ovf_err: got err=%b code=%b cnt=%0d rdy=%b required 1/10/2/0", err2, err_code2, word_count2, in_ready2);
        end
        drive(2'd0, 3, 7'b0010011, 3'b000, 7'd0, 5'd3, 5'd0, 5'd0, 1'b0);
        total++;
        if (mem_we2 !== 1'b0 || word_count2 !== 2'd2) begin
            bad++;
            $display("FAIL ovf_third: got we=%b cnt=%0d required 0/2", mem_we2, word_count2);
        end
        do_reset();
        drive(2'd0, 1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 1'b0);
        ack_once();
        drive(2'd0, 2, 7'b0010011, 3'b000, 7'd0, 5'd2, 5'd0, 5'd0, 1'b1);
        ack_once();
        total++;
        if (done2 !== 1'b1 || err2 !== 1'b0 || err_code2 !== 2'b00 || word_count2 !== 2'd2) begin
            bad++;
            $display("FAIL ovf_last: got done=%b err=%b code=%b cnt=%0d required 1/0/00/2", done2, err2, err_code2, word_count2);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        drive(2'd0, 7, 7'b0010011, 3'b000, 7'd0, 5'd4, 5'd0, 5'd0, 1'b0);
        ack_once();
        drive(2'd0, 9, 7'b0010011, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 1'b0);
        reset = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b0;
        total++;
        if (mem_we !== 1'b0 || word_count !== 9'd0 || mem_addr !== 32'h0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid: got we=%b cnt=%0d addr=%h rdy=%b required 0/0/0/1", mem_we, word_count, mem_addr, in_ready);
        end
        drive(2'd0, 11, 7'b0010011, 3'b000, 7'd0, 5'd6, 5'd0, 5'd0, 1'b0);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h0 ||
            mem_wdata !== ref_word(2'd0, 11, 7'b0010011, 3'b000, 7'd0, 5'd6, 5'd0, 5'd0)) begin
            bad++;
            $display("FAIL rst_mid_next: got we=%b addr=%h data=%h required 1/0/%h", mem_we, mem_addr, mem_wdata,
                     ref_word(2'd0, 11, 7'b0010011, 3'b000, 7'd0, 5'd6, 5'd0, 5'd0));
        end
        ack_once();
    endtask

    task automatic test_random();
        int edge_imms[14] = '{0, 5, -4, 2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097, 3, -1};
        int cnt = 0;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            logic [1:0] f;
            int im;
            logic [6:0] op, f7;
            logic [2:0] f3;
            logic [4:0] d, s1, s2;
            logic l;
            logic [31:0] exp_w;
            logic [31:0] got_w;
            int lat;
            f = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) im = edge_imms[$urandom_range(0, 13)];
            else im = int'($urandom_range(0, 10000)) - 5000;
            op = 7'($urandom); f7 = 7'($urandom); f3 = 3'($urandom);
            d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
            l = ($urandom_range(0, 9) == 0);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL rand_ready[%0d]: got %b required 1", n, in_ready);
            end
            drive(f, im, op, f3, f7, d, s1, s2, l);
            if (!ref_ok(f, im)) begin
                total++;
                if (err !== 1'b1 || err_code !== 2'b01 || mem_we !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_range[%0d]: fmt=%0d imm=%0d got err=%b code=%b we=%b required 1/01/0",
                             n, f, im, err, err_code, mem_we);
                end
                do_reset();
                cnt = 0;
                continue;
            end
            exp_q.push_back(ref_word(f, im, op, f3, f7, d, s1, s2));
            lat = $urandom_range(0, 3);
            repeat (lat) @(negedge clk);
            mem_ack = 1'b1;
            exp_w = exp_q.pop_front();
            got_w = mem_wdata;
            total++;
            if (mem_we !== 1'b1 || got_w !== exp_w || mem_addr !== 32'(cnt * 4)) begin
                bad++;
                $display("FAIL rand_write[%0d]: fmt=%0d imm=%0d got we=%b addr=%h data=%h required 1/%h/%h",
                         n, f, im, mem_we, mem_addr, got_w, 32'(cnt * 4), exp_w);
            end
            @(negedge clk);
            mem_ack = 1'b0;
            cnt++;
            total++;
            if (word_count !== 9'(cnt) || done !== l) begin
                bad++;
                $display("FAIL rand_count[%0d]: got cnt=%0d done=%b required %0d/%b", n, word_count, done, cnt, l);
            end
            if (l) begin
                do_reset();
                cnt = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_i_type();
        test_s_b();
        test_r_stall();
        test_range_errors();
        test_overflow();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_packer.md
# instr_packer

Instruction encoder and program loader for the multicycle core. Accepts decoded instruction fields (opcode, registers, funct bits, signed immediate, format select) over a valid/ready handshake. Packs the immediate into I/S/B/R bit positions, using the same `imm_src` coding the datapath extender consumes. Writes each packed 32-bit word into instruction memory at consecutive word addresses, with range checking and a sticky error/done status.

## Interface

Parameters:
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first written word.
- `MAX_WORDS`, default 256: capacity in words.
- `CNT_W`, default 9: width of `word_count`; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  packer can accept a bundle.
- `in_last`  in  1  bundle is the final instruction of the program.
- `imm_src`  in  2  format: 00 I, 01 S, 10 B, 11 R.
- `imm`  in  32  signed immediate in bytes; ignored for R.
- `opcode`  in  7; `funct3`  in  3; `funct7`  in  7; `rd`  in  5; `rs1`  in  5; `rs2`  in  5.
- `mem_we`  out  1  instruction-memory write strobe.
- `mem_addr`  out  32  byte address, always word aligned.
- `mem_wdata`  out  32  packed instruction.
- `mem_ack`  in  1  memory accepted the write.
- `done`  out  1  program fully written.
- `err`  out  1  sticky error.
- `err_code`  out  2  00 none, 01 immediate out of range/misaligned, 10 capacity overflow.
- `word_count`  out  CNT_W  words successfully written.

## Operation

- Packing of `imm_src` formats:
  - I: imm[11:0]→[31:20], rs1→[19:15], funct3→[14:12], rd→[11:7], opcode→[6:0].
  - S: imm[11:5]→[31:25], rs2→[24:20], rs1, funct3, imm[4:0]→[11:7], opcode.
  - B: imm[12]→31, imm[10:5]→[30:25], rs2, rs1, funct3, imm[4:1]→[11:8], imm[11]→7, opcode.
  - R: funct7→[31:25], rs2, rs1, funct3, rd, opcode.
- Range checks:
  - I/S: -2048 ≤ imm ≤ 2047.
  - B: -4096 ≤ imm ≤ 4094 and imm[0]=0.
  - R: no check.
- FSM states: IDLE, WRITE, DONE, ERR.
  - IDLE: `in_ready`=1. On `in_valid`, the bundle is accepted.
    - Range fail: go to ERR, `err_code`=01, no write.
    - Otherwise: latch the packed word and go to WRITE.
  - WRITE: `mem_we`=1, `mem_addr`=BASE_ADDR+4·`word_count`, `mem_wdata` stable. Hold until `mem_ack`=1 is sampled. On that edge, `word_count` increments and the next state is chosen:
    - `in_last` latched: DONE.
    - else if `word_count`+1 = MAX_WORDS: ERR, `err_code`=10.
    - else: IDLE.
  - DONE: `done`=1, `in_ready`=0. Terminal until reset.
  - ERR: `err`=1, `in_ready`=0. Terminal until reset.
  - A last word that lands exactly at MAX_WORDS goes to DONE, not ERR.
- Reset (active-low, synchronous) values:
  - state=IDLE, `in_ready`=1, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0, `done`=0, `err`=0, `err_code`=00, `word_count`=0.
  - A reset asserted during WRITE drops `mem_we` at that edge. The in-flight word is abandoned; `mem_ack` arriving in the same cycle is ignored.

## Timing

- Bundle accepted on edge N (`in_valid`&`in_ready`). `mem_we` is high from cycle N+1.
- `mem_ack` high in cycle N+1 completes the write at edge N+2. `in_ready` is high again in cycle N+2.
- Minimum throughput: 1 word / 2 cycles.
- `mem_ack` low stretches WRITE indefinitely. Address and data are held constant throughout.
- `mem_ack` outside WRITE is ignored.
- Error detection adds no extra cycle: edge N moves directly to ERR.
- All outputs are registered.

## Structure

- Package `instr_packer_pkg` holds:
  - `imm_src` constants (IMM_I, IMM_S, IMM_B, IMM_R), shared with the extender.
  - state enum.
  - `err_code` constants.
  - immediate limits (I_MIN/I_MAX, B_MIN/B_MAX).
- Sub-module `imm_pack` is purely combinational: fields + `imm_src` → 32-bit word + `range_ok`.
- The top level holds the FSM, address/count registers and output registers.

## Test plan

- I-type: addi x1,x0,5 (opcode 0010011, f3 000, imm 5), mem_ack immediate → write 0x00500093 at addr 0x0; `word_count`=1; `in_ready` back in 2 cycles.
- S and B: sw x2,8(x0) → 0x00202423 at 0x0; then beq x1,x2,-4 with `in_last` → 0xFE208EE3 at 0x4; `done`=1; `in_ready`=0.
- R with stalled ack: add x3,x1,x2, `mem_ack` held low 5 cycles → `mem_we`, addr and data (0x002081B3) stable for 6 cycles; count increments only on ack.
- Range errors: I imm=2048 → `err`=1, code 01, no `mem_we`; after reset, B imm=3 → same code 01; after reset, B imm=4094 → accepted.
- Overflow: MAX_WORDS=2, three bundles with no `in_last` → 2 writes, then ERR code 10 after the second ack. Repeat with `in_last` on the second bundle → DONE, no error.
- Reset mid-WRITE with `mem_ack` high in the same cycle → `mem_we`=0, `word_count`=0, `mem_addr`=BASE_ADDR next cycle; next bundle is written to BASE_ADDR.
